// File: rtl/pri_enc_8_to_3.sv
// pri_enc_8_to_3
// Registered 8-to-3 priority encoder with a valid/ready output handshake.
// Level requests on `in` are latched into a pending register; one encoded
// index is presented at a time and its pending bit clears only on accept.
//
// Build option: define PRI_ENC_ROUND_ROBIN_EN to replace the fixed
// priority select (bit 7 highest) with a round-robin select that scans
// upward from the bit after the last accepted code.
module pri_enc_8_to_3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in,
    input  logic       ready,
    output logic [2:0] enc_out,
    output logic       valid,
    output logic [7:0] pending
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t     state;
    logic       accept;
    logic [7:0] clr;
    logic [7:0] cand;
    logic [2:0] sel;

`ifdef PRI_ENC_ROUND_ROBIN_EN
    logic [2:0] ptr;

    // Round-robin pick: first set bit of c scanning upward from (p+1) mod 8.
    function automatic logic [2:0] select_rr(input logic [7:0] c, input logic [2:0] p);
        logic [2:0] r;
        logic [2:0] idx;
        logic       found;
        r     = 3'd0;
        found = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            idx = p + 3'(i);
            if (!found && c[idx]) begin
                r     = idx;
                found = 1'b1;
            end
        end
        return r;
    endfunction
`else
    // Fixed-priority pick: highest set bit of c wins (bit 7 highest).
    function automatic logic [2:0] select_fixed(input logic [7:0] c);
        logic [2:0] r;
        r = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (c[i]) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction
`endif

    // Accept decode, clear mask and candidate set for the next selection.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        accept = valid && ready;
        clr    = 8'h00;
        if (accept) begin
            clr = 8'h01 << enc_out;
        end
        // Requests arriving this cycle are not candidates until they pend.
        cand = pending & ~clr;
`ifdef PRI_ENC_ROUND_ROBIN_EN
        sel  = select_rr(cand, ptr);
`else
        sel  = select_fixed(cand);
`endif
    end

    // Pending register: clear the accepted code, then OR in new requests so
    // a request held high re-pends across its own accept.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            pending <= 8'h00;
        end else begin
            pending <= (pending & ~clr) | in;
        end
    end

    // Output FSM: present one code, hold it stable until accepted, and
    // reload back-to-back on accept while candidates remain.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            valid   <= 1'b0;
            enc_out <= 3'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (cand != 8'h00) begin
                        enc_out <= sel;
                        valid   <= 1'b1;
                        state   <= HOLD;
                    end
                end
                HOLD: begin
                    if (accept) begin
                        if (cand != 8'h00) begin
                            enc_out <= sel;
                        end else begin
                            // enc_out keeps the last accepted code.
                            valid <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                end
            endcase
        end
    end

`ifdef PRI_ENC_ROUND_ROBIN_EN
    // Round-robin pointer remembers the last accepted code; reset to 7 so
    // bit 0 has first priority after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 3'd7;
        end else if (accept) begin
            ptr <= enc_out;
        end
    end
`endif

endmodule

// File: doc/pri_enc_8_to_3.md
# pri_enc_8_to_3

Registered 8-to-3 priority encoder, the encode-side counterpart of the 3-to-8 decoder. It latches level requests on eight input lines into a pending register and presents one 3-bit code at a time on a valid/ready handshake. A pending bit clears only when its code is accepted. Sits between raw request/event lines and any consumer that needs one encoded index per transfer.

## Interface
- Parameters: none. Width is fixed at 8 request lines and a 3-bit code.
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high; clears all state immediately.
- `in`  in  8  request lines, level-sensitive; bit i requests code i.
- `ready`  in  1  consumer accepts `enc_out` on an edge where `valid && ready`.
- `enc_out`  out  3  encoded index of the presented request; registered.
- `valid`  out  1  `enc_out` holds a pending request; registered.
- `pending`  out  8  current pending register, for status/debug.

## Operation
- **Pending update** every edge: `pending <= (pending & ~clr) | in`.
  - `clr` is the one-hot of `enc_out` when `valid && ready`, otherwise 0.
  - A set from `in` wins over a clear in the same cycle.
- **Candidate set**: `cand = pending & ~clr`. It excludes the code being accepted this cycle and does not include requests arriving this cycle.
- **Select**, fixed priority: the highest set bit of `cand` (bit 7 highest).
- **FSM**, two states:
  - IDLE (`valid=0`): if `cand != 0`, load `enc_out <= select(cand)`, set `valid=1`, go to HOLD. Otherwise stay in IDLE.
  - HOLD (`valid=1`): `enc_out` stays stable while `ready=0`. No preemption by higher-priority arrivals.
  - HOLD on accept (`valid && ready`): if `cand != 0`, load the next code immediately (back-to-back, `valid` stays 1). Otherwise clear `valid` and go to IDLE. `enc_out` keeps its last value.
- **Reset values**: `enc_out=3'd0`, `valid=0`, `pending=8'h00`, state IDLE, round-robin pointer `3'd7`.

## Timing
- Latency: `in[i]` high before edge k sets `pending[i]` at edge k. With the FSM idle, `valid=1` / `enc_out=i` appear at edge k+1.
- Throughput: one code per cycle while `cand` stays non-empty and `ready=1`.
- A level held on `in[i]` keeps re-pending bit i across its own accept. If bit i is the only pending bit, `valid` toggles 1,0,1,0 (code i every other cycle).
- `ready` may change in any cycle. `ready` while `valid=0` has no effect and clears nothing.
- Reset mid-operation: on `rst` assertion all outputs go to reset values asynchronously and pending requests are lost. The first edge after deassertion samples `in` normally.

## Configuration
- Macro `PRI_ENC_ROUND_ROBIN_EN`.
- **Undefined (default)**: fixed priority as above; no pointer register.
- **Defined**: select is round-robin.
  - Scan `cand` upward from `(ptr+1) mod 8` and take the first set bit.
  - On each accept, `ptr <= enc_out` (the accepted code).
  - `ptr` resets to 7, so bit 0 has first priority after reset.
  - Handshake, latency and pending rules are unchanged.

## Test plan
- **Reset**: assert `rst` mid-cycle with `pending=8'h3C`, `valid=1` → `enc_out=0`, `valid=0`, `pending=0` immediately, without waiting for a clock edge.
- **Single request**: `in=8'h04` for one cycle, `ready=1` → `pending=8'h04` after edge 1; `valid=1`, `enc_out=2` after edge 2; `valid=0`, `pending=0` after edge 3.
- **Multi, fixed priority**: `in=8'hA5` for one cycle, `ready=1` → `enc_out` = 7, 5, 2, 0 on four consecutive cycles with `valid` high throughout; then `valid=0`.
- **Backpressure**: `pending=8'h03`, `ready=0`; then `in=8'h80` pulses.
  - `enc_out` must stay 1 until `ready` rises.
  - Then the sequence is 1, 7, 0.
- **Held level**: `in=8'h08` held, `ready=1` → `valid` pattern 1,0,1,0 with `enc_out=3`, and `pending[3]` never clears.
- **Round-robin (`PRI_ENC_ROUND_ROBIN_EN`)**: `in=8'hFF` held, `ready=1` → `enc_out` = 0,1,2,…,7,0 continuously.
  - Without the macro, the same stimulus gives 7,6,7,6.
